// File: rtl/ram_slot_sched_if.sv
// Shared RAM port bundle between the slot scheduler, its bus masters and the SDRAM side.
// The master modport is the requester/RAM side and the slave modport is the scheduler.
interface ram_slot_sched_if #(
    parameter int AW = 23,
    parameter int DW = 64
);
    logic [1:0]    bus_cycle;
    logic          viking_en;
    logic          shf_req;
    logic [AW-1:0] shf_addr;
    logic          vik_req;
    logic [AW-1:0] vik_addr;
    logic          cpu_req;
    logic          cpu_we;
    logic [1:0]    cpu_ds;
    logic [AW-1:0] cpu_addr;
    logic [15:0]   cpu_din;
    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [15:0]   dma_din;
    logic [AW-1:0] ram_addr;
    logic          ram_oe;
    logic          ram_we;
    logic [1:0]    ram_ds;
    logic [15:0]   ram_din;
    logic [DW-1:0] ram_dout;
    logic [2:0]    owner;
    logic [DW-1:0] rd_data;
    logic          shf_valid;
    logic          cpu_valid;
    logic          vik_valid;
    logic          dma_valid;

    modport master (
        input  bus_cycle, ram_addr, ram_oe, ram_we, ram_ds, ram_din, owner, rd_data,
               shf_valid, cpu_valid, vik_valid, dma_valid,
        output viking_en, shf_req, shf_addr, vik_req, vik_addr, cpu_req, cpu_we, cpu_ds,
               cpu_addr, cpu_din, dma_req, dma_we, dma_addr, dma_din, ram_dout
    );

    modport slave (
        input  viking_en, shf_req, shf_addr, vik_req, vik_addr, cpu_req, cpu_we, cpu_ds,
               cpu_addr, cpu_din, dma_req, dma_we, dma_addr, dma_din, ram_dout,
        output bus_cycle, ram_addr, ram_oe, ram_we, ram_ds, ram_din, owner, rd_data,
               shf_valid, cpu_valid, vik_valid, dma_valid
    );
endinterface

// File: rtl/ram_slot_sched.sv
// Four-slot RAM port scheduler: one owner per 8 MHz slot, strobes held for the whole slot.
// Read data returns with a one-clk_32 valid on the boundary closing the slot; no backpressure, no queue.
module ram_slot_sched #(
    parameter int AW = 23,
    parameter int DW = 64
) (
    input  logic              clk_32,
    input  logic              reset_n,
    input  logic              clk_8_en,
    ram_slot_sched_if.slave   bus
);
    typedef enum logic [2:0] {
        OWN_NONE = 3'd0,
        OWN_SHF  = 3'd1,
        OWN_CPU  = 3'd2,
        OWN_VIK  = 3'd3,
        OWN_DMA  = 3'd4
    } owner_t;

    owner_t        owner_q, owner_nxt;
    logic [1:0]    cycle_q, cycle_nxt;
    logic [AW-1:0] addr_q, addr_nxt;
    logic          oe_q, oe_nxt;
    logic          we_q, we_nxt;
    logic [1:0]    ds_q, ds_nxt;
    logic [15:0]   din_q, din_nxt;
    logic [DW-1:0] rd_q;
    logic [3:0]    vld_q;   // {dma, vik, cpu, shf}

    always_comb begin
        cycle_nxt = cycle_q + 2'd1;
        owner_nxt = OWN_NONE;
        addr_nxt  = '0;
        oe_nxt    = 1'b0;
        we_nxt    = 1'b0;
        ds_nxt    = 2'b00;
        din_nxt   = 16'h0000;

        unique case (cycle_nxt)
            2'd0: if (bus.shf_req) owner_nxt = OWN_SHF;
            2'd1: if (bus.cpu_req) owner_nxt = OWN_CPU;
            2'd2: begin
                if (bus.viking_en && bus.vik_req) owner_nxt = OWN_VIK;
                else if (bus.dma_req)             owner_nxt = OWN_DMA;
                else if (bus.cpu_req)             owner_nxt = OWN_CPU;
            end
            default: begin
                if (bus.dma_req)      owner_nxt = OWN_DMA;
                else if (bus.cpu_req) owner_nxt = OWN_CPU;
            end
        endcase

        case (owner_nxt)
            OWN_SHF: begin
                addr_nxt = bus.shf_addr;
                oe_nxt   = 1'b1;
                ds_nxt   = 2'b11;
            end
            OWN_VIK: begin
                addr_nxt = bus.vik_addr;
                oe_nxt   = 1'b1;
                ds_nxt   = 2'b11;
            end
            OWN_CPU: begin
                addr_nxt = bus.cpu_addr;
                we_nxt   = bus.cpu_we;
                oe_nxt   = ~bus.cpu_we;
                ds_nxt   = bus.cpu_we ? bus.cpu_ds : 2'b11;
                din_nxt  = bus.cpu_we ? bus.cpu_din : 16'h0000;
            end
            OWN_DMA: begin
                addr_nxt = bus.dma_addr;
                we_nxt   = bus.dma_we;
                oe_nxt   = ~bus.dma_we;
                ds_nxt   = 2'b11;
                din_nxt  = bus.dma_we ? bus.dma_din : 16'h0000;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_32 or negedge reset_n) begin
        if (!reset_n) begin
            cycle_q <= 2'd3;
            owner_q <= OWN_NONE;
            addr_q  <= '0;
            oe_q    <= 1'b0;
            we_q    <= 1'b0;
            ds_q    <= 2'b00;
            din_q   <= 16'h0000;
            rd_q    <= '0;
            vld_q   <= 4'b0000;
        end else begin
            vld_q <= 4'b0000;
            if (clk_8_en) begin
                // The closing edge of a read slot is where the RAM data is guaranteed settled.
                if (oe_q) begin
                    rd_q <= bus.ram_dout;
                    case (owner_q)
                        OWN_SHF: vld_q <= 4'b0001;
                        OWN_CPU: vld_q <= 4'b0010;
                        OWN_VIK: vld_q <= 4'b0100;
                        OWN_DMA: vld_q <= 4'b1000;
                        default: vld_q <= 4'b0000;
                    endcase
                end
                cycle_q <= cycle_nxt;
                owner_q <= owner_nxt;
                addr_q  <= addr_nxt;
                oe_q    <= oe_nxt;
                we_q    <= we_nxt;
                ds_q    <= ds_nxt;
                din_q   <= din_nxt;
            end
        end
    end

    assign bus.bus_cycle = cycle_q;
    assign bus.owner     = owner_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_oe    = oe_q;
    assign bus.ram_we    = we_q;
    assign bus.ram_ds    = ds_q;
    assign bus.ram_din   = din_q;
    assign bus.rd_data   = rd_q;
    assign bus.shf_valid = vld_q[0];
    assign bus.cpu_valid = vld_q[1];
    assign bus.vik_valid = vld_q[2];
    assign bus.dma_valid = vld_q[3];
endmodule

// File: tb/tb_ram_slot_sched.sv
// Randomised bench for ram_slot_sched against a slot-level reference model.
module tb_ram_slot_sched;
    localparam int AW = 23;
    localparam int DW = 64;

    logic clk_32 = 1'b0;
    logic reset_n = 1'b0;
    logic clk_8_en = 1'b0;

    ram_slot_sched_if #(.AW(AW), .DW(DW)) bus();

    ram_slot_sched #(.AW(AW), .DW(DW)) dut (
        .clk_32   (clk_32),
        .reset_n  (reset_n),
        .clk_8_en (clk_8_en),
        .bus      (bus.slave)
    );

    always #5 clk_32 = ~clk_32;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: slot number, granted requester and what that requester put on the port.
    int            m_slot;
    int            m_owner;
    logic [AW-1:0] m_addr;
    logic          m_oe, m_we;
    logic [1:0]    m_ds;
    logic [15:0]   m_din;
    logic [DW-1:0] m_rd;
    logic [3:0]    m_val;

    int phase;
    int stall_left;
    int en_seen;
    int vld_cnt[4];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_slot = 3; m_owner = 0; m_addr = '0; m_oe = 0; m_we = 0;
        m_ds = 0; m_din = 0; m_rd = '0; m_val = 0;
    endtask

    function automatic int pick_owner(input int slot);
        case (slot)
            0: return bus.shf_req ? 1 : 0;
            1: return bus.cpu_req ? 2 : 0;
            2: return (bus.viking_en && bus.vik_req) ? 3 : bus.dma_req ? 4 : bus.cpu_req ? 2 : 0;
            default: return bus.dma_req ? 4 : bus.cpu_req ? 2 : 0;
        endcase
    endfunction

    task automatic model_step();
        m_val = 0;
        if (clk_8_en) begin
            if (m_oe) begin
                m_rd = bus.ram_dout;
                m_val[m_owner-1] = 1'b1;
            end
            m_slot  = (m_slot + 1) % 4;
            m_owner = pick_owner(m_slot);
            m_addr = '0; m_oe = 0; m_we = 0; m_ds = 2'b00; m_din = 16'h0;
            case (m_owner)
                1: begin m_addr = bus.shf_addr; m_oe = 1; m_ds = 2'b11; end
                3: begin m_addr = bus.vik_addr; m_oe = 1; m_ds = 2'b11; end
                2: begin
                    m_addr = bus.cpu_addr;
                    if (bus.cpu_we) begin m_we = 1; m_ds = bus.cpu_ds; m_din = bus.cpu_din; end
                    else begin m_oe = 1; m_ds = 2'b11; end
                end
                4: begin
                    m_addr = bus.dma_addr; m_ds = 2'b11;
                    if (bus.dma_we) begin m_we = 1; m_din = bus.dma_din; end
                    else m_oe = 1;
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_all();
        chk("bus_cycle", 64'(bus.bus_cycle), 64'(m_slot));
        chk("owner",     64'(bus.owner),     64'(m_owner));
        chk("ram_addr",  64'(bus.ram_addr),  64'(m_addr));
        chk("ram_strb",  64'({bus.ram_oe, bus.ram_we, bus.ram_ds}), 64'({m_oe, m_we, m_ds}));
        chk("ram_din",   64'(bus.ram_din),   64'(m_din));
        chk("rd_data",   bus.rd_data,        m_rd);
        chk("valids",    64'({bus.dma_valid, bus.vik_valid, bus.cpu_valid, bus.shf_valid}), 64'(m_val));
    endtask

    task automatic tick();
        clk_8_en = (phase == 3) && (stall_left == 0);
        @(posedge clk_32);
        model_step();
        if (clk_8_en) en_seen++;
        if (stall_left > 0) stall_left--;
        else phase = (phase + 1) % 4;
        #1;
        compare_all();
        vld_cnt[0] += int'(bus.shf_valid);
        vld_cnt[1] += int'(bus.cpu_valid);
        vld_cnt[2] += int'(bus.vik_valid);
        vld_cnt[3] += int'(bus.dma_valid);
        bus.ram_dout = {$urandom, $urandom};
    endtask

    task automatic run_slots(input int n);
        int start;
        start = en_seen;
        for (int i = 0; i < 8 * n + 40 && en_seen < start + n; i++) tick();
        if (en_seen < start + n) chk("slot_timeout", 64'(en_seen - start), 64'(n));
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) vld_cnt[i] = 0;
    endtask

    task automatic idle_inputs();
        bus.viking_en = 0; bus.shf_req = 0; bus.vik_req = 0; bus.cpu_req = 0;
        bus.cpu_we = 0; bus.cpu_ds = 0; bus.dma_req = 0; bus.dma_we = 0;
        bus.shf_addr = '0; bus.vik_addr = '0; bus.cpu_addr = '0; bus.dma_addr = '0;
        bus.cpu_din = 0; bus.dma_din = 0;
    endtask

    task automatic rand_inputs();
        bus.viking_en = 1'($urandom);
        bus.shf_req   = 1'($urandom);
        bus.vik_req   = 1'($urandom);
        bus.cpu_req   = 1'($urandom);
        bus.cpu_we    = 1'($urandom);
        bus.cpu_ds    = 2'($urandom);
        bus.dma_req   = 1'($urandom);
        bus.dma_we    = 1'($urandom);
        bus.shf_addr  = AW'($urandom);
        bus.vik_addr  = AW'($urandom);
        bus.cpu_addr  = AW'($urandom);
        bus.dma_addr  = AW'($urandom);
        bus.cpu_din   = 16'($urandom);
        bus.dma_din   = 16'($urandom);
    endtask

    task automatic run_until_slot(input int s);
        int k;
        k = 0;
        while (m_slot != s && k < 40) begin tick(); k++; end
        if (m_slot != s) chk("wait_slot", 64'(m_slot), 64'(s));
    endtask

    initial begin
        logic [AW-1:0] held_addr;
        idle_inputs();
        bus.ram_dout = '0;
        model_reset();
        phase = 0; stall_left = 0; en_seen = 0;
        clear_counts();

        #12;
        compare_all();
        @(negedge clk_32);
        reset_n = 1'b1;

        // Idle: slots walk 0..3 twice with nothing on the port.
        run_slots(8);

        // Shifter read in slot 0 with a fixed data word.
        bus.shf_req = 1; bus.shf_addr = 23'h03F000;
        clear_counts();
        for (int i = 0; i < 8 * 4 + 4 && en_seen < 16 + 8; i++) begin
            bus.ram_dout = 64'h0123456789ABCDEF;
            clk_8_en = (phase == 3);
            @(posedge clk_32);
            model_step();
            if (clk_8_en) en_seen++;
            phase = (phase + 1) % 4;
            #1;
            compare_all();
            vld_cnt[0] += int'(bus.shf_valid);
        end
        chk("shf_valid_cnt", 64'(vld_cnt[0]), 64'd2);
        chk("shf_rd_data", bus.rd_data, 64'h0123456789ABCDEF);
        idle_inputs();

        // Viking beats DMA in slot 2; DMA takes slot 3.
        bus.viking_en = 1; bus.vik_req = 1; bus.dma_req = 1;
        bus.vik_addr = 23'h100000; bus.dma_addr = 23'h200000;
        run_until_slot(1);
        tick();
        run_slots(1);
        chk("slot2_vik", 64'(bus.owner), 64'd3);
        run_slots(1);
        chk("slot3_dma", 64'(bus.owner), 64'd4);

        bus.viking_en = 0;
        clear_counts();
        run_slots(8);
        chk("vik_valid_off", 64'(vld_cnt[2]), 64'd0);
        idle_inputs();

        // CPU writes occupy slots 1..3 without read strobes.
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_ds = 2'b10; bus.cpu_din = 16'hBEEF;
        clear_counts();
        run_slots(8);
        chk("cpu_wr_valid", 64'(vld_cnt[1]), 64'd0);
        idle_inputs();

        // Randomised traffic with occasional missing slot pulses.
        for (int i = 0; i < 600; i++) begin
            rand_inputs();
            if (stall_left == 0 && $urandom_range(0, 40) == 0) stall_left = $urandom_range(1, 9);
            tick();
        end
        stall_left = 0;

        // Missing clk_8_en during slot 1.
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 23'h012345;
        run_until_slot(1);
        held_addr = bus.ram_addr;
        stall_left = 12;
        for (int i = 0; i < 14; i++) tick();
        chk("stall_cycle", 64'(bus.bus_cycle), 64'd1);
        chk("stall_addr", 64'(bus.ram_addr), 64'(held_addr));
        run_slots(2);
        idle_inputs();

        // Reset mid-way through a Viking read in slot 2.
        bus.viking_en = 1; bus.vik_req = 1; bus.vik_addr = 23'h055555;
        run_until_slot(2);
        tick();
        chk("vik_oe_pre", 64'(bus.ram_oe), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_oe", 64'(bus.ram_oe), 64'd0);
        compare_all();
        repeat (2) @(negedge clk_32);
        reset_n = 1'b1;
        phase = 0;
        clear_counts();
        bus.vik_req = 0;
        run_slots(3);
        chk("rst_vik_valid", 64'(vld_cnt[2]), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
